// File: rtl/instr_encoder_if.sv
// Stream interface of the instruction encoder: descriptor input, encoded-word
// output and status signals.
interface instr_encoder_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  In_Valid;
    logic                  In_Ready;
    logic [1:0]            In_Class;
    logic [3:0]            In_Cond;
    logic [3:0]            In_Cmd;
    logic                  In_S;
    logic                  In_L;
    logic                  In_U;
    logic [3:0]            In_Rd;
    logic [3:0]            In_Rn;
    logic [3:0]            In_Rm;
    logic [3:0]            In_Rot;
    logic [23:0]           In_Imm;
    logic                  Out_Valid;
    logic                  Out_Ready;
    logic [31:0]           Out_Instr;
    logic [ADDR_WIDTH-1:0] Out_Addr;
    logic                  Err;
    logic                  Halted;
    logic [ADDR_WIDTH:0]   Count;

    modport master (
        output In_Valid, In_Class, In_Cond, In_Cmd, In_S, In_L, In_U,
               In_Rd, In_Rn, In_Rm, In_Rot, In_Imm, Out_Ready,
        input  In_Ready, Out_Valid, Out_Instr, Out_Addr, Err, Halted, Count
    );

    modport slave (
        input  In_Valid, In_Class, In_Cond, In_Cmd, In_S, In_L, In_U,
               In_Rd, In_Rn, In_Rm, In_Rot, In_Imm, Out_Ready,
        output In_Ready, Out_Valid, Out_Instr, Out_Addr, Err, Halted, Count
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs field-level instruction descriptors into 32-bit ARM words, tags each
// with a sequential word address and buffers them in a small FIFO.
module instr_encoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 9,
    parameter int BASE_ADDR  = 0
) (
    input  logic CLK,
    input  logic RESET,
    input  logic Start,
    instr_encoder_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic {RUN, HALT} state_t;

    state_t                state, state_next;
    logic [PTR_W:0]        wr_ptr, rd_ptr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   count;
    logic                  err_p1;
    logic [31:0]           mem_instr [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_addr  [FIFO_DEPTH];

    logic        full, empty, in_ready, hs, pop;
    logic        bad_p0, vld_p0;
    logic [31:0] word_p0;

    function automatic logic cmd_ok(input logic [3:0] cmd);
        case (cmd)
            4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010, 4'b1011: cmd_ok = 1'b1;
            default:                                            cmd_ok = 1'b0;
        endcase
    endfunction

    function automatic logic is_bad(input logic [1:0] cls, input logic [3:0] cond,
                                    input logic [3:0] cmd, input logic [23:0] imm);
        logic b;
        b = (cond == 4'hF);
        if (!cls[1] && !cmd_ok(cmd))     b = 1'b1;
        if (cls == 2'b01 && imm[23:8]  != '0) b = 1'b1;
        if (cls == 2'b10 && imm[23:12] != '0) b = 1'b1;
        is_bad = b;
    endfunction

    function automatic logic [31:0] encode(
        input logic [1:0] cls, input logic [3:0] cond, input logic [3:0] cmd,
        input logic s, input logic l, input logic u, input logic [3:0] rd,
        input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rot,
        input logic [23:0] imm);
        logic       cmp;
        logic       s_eff;
        logic [3:0] rd_eff;
        // Compare ops always set flags and have no destination register.
        cmp    = (cmd == 4'b1010) || (cmd == 4'b1011);
        s_eff  = cmp ? 1'b1 : s;
        rd_eff = cmp ? 4'b0000 : rd;
        case (cls)
            2'b00:   encode = {cond, 3'b000, cmd, s_eff, rn, rd_eff, 8'h00, rm};
            2'b01:   encode = {cond, 3'b001, cmd, s_eff, rn, rd_eff, rot, imm[7:0]};
            2'b10:   encode = {cond, 3'b010, 1'b1, u, 1'b0, 1'b0, l, rn, rd, imm[11:0]};
            default: encode = {cond, 4'b1010, imm};
        endcase
    endfunction

    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign in_ready = (state == RUN) && !full && !Start;
    assign hs       = bus.In_Valid && in_ready;
    assign pop      = !empty && bus.Out_Ready;

    // Stage p0: combinational encode and legality check of the offered descriptor
    assign bad_p0  = is_bad(bus.In_Class, bus.In_Cond, bus.In_Cmd, bus.In_Imm);
    assign word_p0 = encode(bus.In_Class, bus.In_Cond, bus.In_Cmd, bus.In_S, bus.In_L,
                            bus.In_U, bus.In_Rd, bus.In_Rn, bus.In_Rm, bus.In_Rot,
                            bus.In_Imm);
    assign vld_p0  = hs && !bad_p0;

    always_comb begin
        state_next = state;
        if (Start)
            state_next = RUN;
        else if (state == RUN && vld_p0 && addr == '1)
            state_next = HALT;
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            state <= RUN;
        else
            state <= state_next;
    end

    // Stage p1: FIFO, address counter and error pulse
    always_ff @(posedge CLK) begin
        if (RESET || Start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            addr   <= BASE;
            count  <= '0;
            err_p1 <= 1'b0;
        end else begin
            err_p1 <= hs && bad_p0;
            if (vld_p0) begin
                wr_ptr <= wr_ptr + 1'b1;
                addr   <= addr + 1'b1;
                count  <= count + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (vld_p0) begin
            mem_instr[wr_ptr[PTR_W-1:0]] <= word_p0;
            mem_addr[wr_ptr[PTR_W-1:0]]  <= addr;
        end
    end

    assign bus.In_Ready  = in_ready;
    assign bus.Out_Valid = !empty;
    assign bus.Out_Instr = empty ? 32'h0 : mem_instr[rd_ptr[PTR_W-1:0]];
    assign bus.Out_Addr  = empty ? '0 : mem_addr[rd_ptr[PTR_W-1:0]];
    assign bus.Err       = err_p1;
    assign bus.Halted    = (state == HALT);
    assign bus.Count     = count;
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Producer-side counterpart of the core's instruction decoder.
- Accepts field-level instruction descriptions over a valid/ready stream and packs them into 32-bit ARM words. It covers the subset the decoder executes: DP reg/imm ADD/SUB/AND/ORR/CMP/CMN, LDR/STR with immediate offset, and B.
- Assigns each accepted word a sequential word address and buffers it in a small FIFO toward the instruction-memory loader.
- Rejects encodings the datapath cannot execute.

Parameters:
- FIFO_DEPTH, 4: output buffer entries; power of 2, ≥2.
- ADDR_WIDTH, 9: width of the word-address counter.
- BASE_ADDR, 0: word address assigned to the first instruction after reset/Start.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- Start  in  1  restart pulse: flush FIFO, address := BASE_ADDR, clear Halted.
- In_Valid  in  1  input descriptor valid.
- In_Ready  out  1  descriptor accepted when In_Valid & In_Ready.
- In_Class  in  2  instruction class: 00 DP reg, 01 DP imm, 10 memory, 11 branch.
- In_Cond  in  4  condition field.
- In_Cmd  in  4  DP cmd: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP, 1011 CMN.
- In_S  in  1  set-flags bit (DP only).
- In_L  in  1  1=LDR, 0=STR.
- In_U  in  1  1=add offset, 0=subtract.
- In_Rd / In_Rn / In_Rm  in  4 each  register numbers.
- In_Rot  in  4  DP-imm rotate field.
- In_Imm  in  24  immediate: imm8 (DP), imm12 (mem), imm24 (B).
- Out_Valid  out  1  FIFO head valid.
- Out_Ready  in  1  consumer takes the head when Out_Valid & Out_Ready.
- Out_Instr  out  32  encoded word at FIFO head.
- Out_Addr  out  ADDR_WIDTH  word address of the head.
- Err  out  1  one-cycle pulse: the handshaked descriptor was rejected.
- Halted  out  1  address space exhausted.
- Count  out  ADDR_WIDTH+1  number of words accepted since reset/Start.

Behaviour:
- Reset (RESET=1 at a clock edge):
  - FIFO emptied; Out_Valid=0, Out_Instr=0, Out_Addr=0.
  - Err=0, Halted=0, Count=0; address counter := BASE_ADDR; FSM := RUN.
- Out_Instr and Out_Addr read 0 whenever Out_Valid=0.
- In_Ready = (state==RUN) & !fifo_full & !Start. It is combinational and must not depend on In_Valid.
- Encoding (bit fields MSB→LSB):
  - DP reg: cond,00,0,cmd,S,Rn,Rd,8'h00,Rm.
  - DP imm: cond,00,1,cmd,S,Rn,Rd,Rot,Imm[7:0].
  - Memory: cond,01,0,1(P),U,0(B),0(W),L,Rn,Rd,Imm[11:0].
  - Branch: cond,1010,Imm[23:0].
  - For CMP/CMN, S is forced to 1 and Rd to 0000.
- Rejection rules: a handshaked descriptor is rejected if any of the following holds.
  - In_Cond=1111.
  - DP with In_Cmd outside the six listed.
  - DP imm with Imm[23:8]≠0.
  - Memory with Imm[23:12]≠0.
- On rejection:
  - Err=1 for exactly the next cycle.
  - Nothing is enqueued; address counter and Count are unchanged.
  - The handshake still completes, so the producer moves on.
- On acceptance:
  - The word and current address are written to the FIFO tail at the clock edge, so latency is 1 cycle: Out_Valid rises the cycle after the handshake if the FIFO was empty.
  - Address counter +1; Count +1.
- FIFO:
  - First-in-first-out order.
  - Push and pop in the same cycle are both honoured when not full; occupancy is unchanged.
  - No pass-through: a full FIFO blocks the input even if Out_Ready=1 that cycle.
  - Pop on empty is ignored.
- FSM:
  - RUN→HALT when a word is accepted at address 2^ADDR_WIDTH−1; Halted=1 from the next cycle.
  - In HALT: In_Ready=0, but the FIFO still drains.
  - HALT→RUN only on Start or RESET.
- Start:
  - Takes effect at the clock edge and has priority over any handshake that cycle; that input is not accepted because In_Ready=0.
  - Any pop in that cycle is discarded.
  - Next cycle: FIFO empty, address=BASE_ADDR, Count=0, Halted=0, state RUN.
- RESET asserted mid-stream discards buffered words identically.
- RESET has priority over Start.

Test Plan:
1. DP imm cond=E cmd=0100 S=0 Rn=2 Rd=1 Rot=0 Imm=5 → next cycle Out_Valid=1, Out_Instr=0xE2821005, Out_Addr=0, Count=1.
2. Memory LDR R3,[R4,#8] (L=1,U=1) then STR R3,[R4,#-8] (L=0,U=0) → 0xE5943008 @addr0, then 0xE5043008 @addr1. DP reg CMP cmd=1010 S=0 Rd=5 Rn=0 Rm=1 → 0xE1500001 (S forced, Rd zeroed).
3. Branch cond=E Imm=0xFFFFFE → 0xEAFFFFFE. Then DP cmd=1101 (MOV) → Err high one cycle, no Out_Valid, Count and next address unchanged.
4. Backpressure:
   - Out_Ready=0, push 5 valid descriptors back-to-back → In_Ready=0 after the 4th; 5th held.
   - Set Out_Ready=1 → words emerge addr 0,1,2,3 in order; the 5th is accepted once space frees and emerges with addr 4.
5. ADDR_WIDTH=2:
   - Accept 4 words → Halted=1, In_Ready=0, FIFO drains normally.
   - Pulse Start with In_Valid=1 → input not accepted; next cycle Halted=0, Count=0; the next accepted word has Out_Addr=0.
6. RESET with 3 words buffered → next cycle Out_Valid=0, Out_Instr=0, Count=0; following word at BASE_ADDR.
